// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
// Shared types and defaults for the instruction-fetch sequencing controller.
//   state_t : controller states (BOOT, RUN, FLUSH)
//   src_t   : redirect source, in priority order trap > branch > jump
//   DEF_*   : default values for the fetch_ctrl parameters
//   sel_src : priority selection of the active redirect source
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_TRAP   = 2'd1,
        SRC_BRANCH = 2'd2,
        SRC_JUMP   = 2'd3
    } src_t;

    localparam int          DEF_BOOT_CYCLES     = 3;
    localparam int          DEF_FLUSH_CYCLES    = 2;
    localparam logic [31:0] DEF_MISALIGN_VECTOR = 32'h0000_0010;

    // Width of the boot and flush down-counters.
    localparam int          CNT_W               = 8;

    // Trap beats branch beats jump.
    function automatic src_t sel_src(input logic i_trap,
                                     input logic i_branch,
                                     input logic i_jump);
        if (i_trap)
            return SRC_TRAP;
        else if (i_branch)
            return SRC_BRANCH;
        else if (i_jump)
            return SRC_JUMP;
        else
            return SRC_NONE;
    endfunction

endpackage

// File: rtl/fetch_ctrl_rst_sync.sv
// rst_sync
// Two-flop reset synchronizer: asserts asynchronously when i_rst_n goes low,
// deasserts on the second rising i_clk edge after i_rst_n rises.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   o_rst   : synchronous active-high reset
module rst_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_rst
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= 1'b0;
            r_sync <= r_meta;
        end
    end

    assign o_rst = r_sync;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Sequencing controller for the instruction-fetch stage. Merges trap, branch
// and jump redirects with the hazard stall into stop / load_next_pc / next_pc,
// tracks the wrong-path bubbles after a redirect, flags valid instructions to
// decode, and generates the fetch stage's synchronous reset.
//   clk, rst_n          : clock, asynchronous active-low reset
//   stall_req           : hazard stall request
//   trap_req/vector     : trap redirect
//   branch_taken/target : execute-stage taken branch
//   jump_req/target     : decode-stage JAL/JALR
//   fetch_rst           : synchronous active-high reset to the fetch stage
//   stop                : hold the PC
//   load_next_pc        : load next_pc into the fetch stage
//   next_pc             : selected redirect target (0 when idle)
//   inst_valid          : word presented to decode is on the correct path
//   flush_id            : kill the IF/ID register
//   misalign_exc        : one-cycle pulse, misaligned target was replaced
//   misalign_addr       : raw misaligned target captured with the pulse
//   redirect_cnt        : saturating count of accepted redirects
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int          BOOT_CYCLES     = DEF_BOOT_CYCLES,
    parameter int          FLUSH_CYCLES    = DEF_FLUSH_CYCLES,
    parameter logic [31:0] MISALIGN_VECTOR = DEF_MISALIGN_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_req,
    input  logic        trap_req,
    input  logic [31:0] trap_vector,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_req,
    input  logic [31:0] jump_target,
    output logic        fetch_rst,
    output logic        stop,
    output logic        load_next_pc,
    output logic [31:0] next_pc,
    output logic        inst_valid,
    output logic        flush_id,
    output logic        misalign_exc,
    output logic [31:0] misalign_addr,
    output logic [15:0] redirect_cnt
);

    logic             w_fetch_rst;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_boot_cnt;
    logic [CNT_W-1:0] w_boot_cnt_nxt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] w_flush_cnt_nxt;

    src_t             w_src;
    logic [31:0]      w_raw_tgt;
    logic             w_active;
    logic             w_redirect;
    logic             w_misalign;

    logic             r_mis_prev;
    logic             r_misalign_exc;
    logic [31:0]      r_misalign_addr;
    logic [15:0]      r_redirect_cnt;

    rst_sync u_rst_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .o_rst   (w_fetch_rst)
    );

    // Requests only count once BOOT has finished; during BOOT they are ignored.
    always_comb begin
        w_active   = (r_state != BOOT);
        w_src      = w_active ? sel_src(trap_req, branch_taken, jump_req) : SRC_NONE;
        w_redirect = (w_src != SRC_NONE);
        unique case (w_src)
            SRC_TRAP:   w_raw_tgt = trap_vector;
            SRC_BRANCH: w_raw_tgt = branch_target;
            SRC_JUMP:   w_raw_tgt = jump_target;
            default:    w_raw_tgt = 32'h0;
        endcase
        w_misalign = w_redirect && (w_raw_tgt[1:0] != 2'b00);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= BOOT;
            r_boot_cnt  <= CNT_W'(BOOT_CYCLES);
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_boot_cnt  <= w_boot_cnt_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // Next-state logic. The counters leave their state on the edge where
    // they reach zero, so FLUSH lasts exactly FLUSH_CYCLES cycles.
    always_comb begin
        w_state_nxt     = r_state;
        w_boot_cnt_nxt  = r_boot_cnt;
        w_flush_cnt_nxt = r_flush_cnt;
        unique case (r_state)
            BOOT: begin
                if (!w_fetch_rst) begin
                    if (r_boot_cnt <= CNT_W'(1)) begin
                        w_boot_cnt_nxt = '0;
                        w_state_nxt    = RUN;
                    end else begin
                        w_boot_cnt_nxt = r_boot_cnt - CNT_W'(1);
                    end
                end
            end
            RUN: begin
                if (w_redirect) begin
                    w_state_nxt     = FLUSH;
                    w_flush_cnt_nxt = CNT_W'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                // Stall does not freeze the flush: the cache read still retires.
                if (w_redirect) begin
                    w_flush_cnt_nxt = CNT_W'(FLUSH_CYCLES);
                end else if (r_flush_cnt <= CNT_W'(1)) begin
                    w_flush_cnt_nxt = '0;
                    w_state_nxt     = RUN;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    // Outputs. A redirect may coincide with a stall: the fetch stage loads
    // the target even while stop is high.
    always_comb begin
        stop         = w_active && stall_req;
        load_next_pc = w_redirect;
        flush_id     = w_redirect;
        inst_valid   = (r_state == RUN) && !w_redirect;
        if (!w_redirect)
            next_pc = 32'h0;
        else if (w_misalign)
            next_pc = MISALIGN_VECTOR;
        else
            next_pc = w_raw_tgt;
    end

    // Misalign pulse fires only on the first cycle of a misaligned redirect,
    // so a request held for several cycles raises a single exception.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mis_prev      <= 1'b0;
            r_misalign_exc  <= 1'b0;
            r_misalign_addr <= 32'h0;
            r_redirect_cnt  <= 16'h0;
        end else begin
            r_mis_prev     <= w_misalign;
            r_misalign_exc <= w_misalign && !r_mis_prev;
            if (w_misalign && !r_mis_prev)
                r_misalign_addr <= w_raw_tgt;
            if (w_redirect && (r_redirect_cnt != 16'hFFFF))
                r_redirect_cnt <= r_redirect_cnt + 16'd1;
        end
    end

    assign fetch_rst     = w_fetch_rst;
    assign misalign_exc  = r_misalign_exc;
    assign misalign_addr = r_misalign_addr;
    assign redirect_cnt  = r_redirect_cnt;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the instruction-fetch stage. Merges redirect sources (trap, branch, jump) and the hazard stall into the fetch stage's `stop` / `load_next_pc` / `next_pc` controls. Tracks the wrong-path bubbles caused by the 1-cycle instruction-cache read latency and tells decode which fetched words are valid. Also generates the fetch stage's synchronous active-high reset from the core reset.

## Interface
Parameters:
- `BOOT_CYCLES`, 3: cycles after `fetch_rst` falls before the first valid instruction.
- `FLUSH_CYCLES`, 2: wrong-path bubbles after a redirect (PC register plus cache read).
- `MISALIGN_VECTOR`, 32'h0000_0010: target used when a redirect target is not word-aligned.

Ports:
- One clock; reset is asynchronous and active-low. Ports `clk` and `rst_n`.
- `clk`  in  1  core clock.
- `rst_n`  in  1  async active-low reset.
- `stall_req`  in  1  hazard-unit stall request.
- `trap_req`  in  1  trap redirect request.
- `trap_vector`  in  32  trap target.
- `branch_taken`  in  1  execute-stage taken branch.
- `branch_target`  in  32  branch target.
- `jump_req`  in  1  decode-stage JAL/JALR redirect.
- `jump_target`  in  32  jump target.
- `fetch_rst`  out  1  sync active-high reset to the fetch stage.
- `stop`  out  1  hold the PC.
- `load_next_pc`  out  1  load `next_pc` into the fetch stage.
- `next_pc`  out  32  selected redirect target.
- `inst_valid`  out  1  instruction presented to decode is on the correct path.
- `flush_id`  out  1  kill the IF/ID register.
- `misalign_exc`  out  1  one-cycle pulse: misaligned target replaced.
- `misalign_addr`  out  32  offending target, captured on the pulse.
- `redirect_cnt`  out  16  saturating count of accepted redirects.

## Operation
- States: `BOOT`, `RUN`, `FLUSH`. Stall is orthogonal to state and is not a state.
- Reset values:
  - state=`BOOT`; boot counter = `BOOT_CYCLES`; flush counter = 0.
  - `fetch_rst`=1, `inst_valid`=0, `misalign_exc`=0, `misalign_addr`=0, `redirect_cnt`=0.
- `fetch_rst` comes from a 2-flop synchronizer. Assertion is asynchronous on `rst_n` low; deassertion occurs on the 2nd rising `clk` edge after `rst_n` rises.
- `BOOT`: the counter decrements each cycle while `fetch_rst`=0. Go to `RUN` when it reaches 0. In `BOOT`, all request inputs are ignored: `stop`=0, `load_next_pc`=0, `inst_valid`=0.
- Redirect priority is trap > branch > jump. A redirect is any of the three requests asserted in `RUN` or `FLUSH`.
- `load_next_pc` and `next_pc` are combinational from the request inputs, in the same cycle. When no redirect is active, `next_pc`=0.
- If the selected target has bits [1:0] != 0:
  - `next_pc` = `MISALIGN_VECTOR`.
  - `misalign_exc` pulses on the next cycle.
  - `misalign_addr` holds the raw target.
- On a redirect:
  - go to (or stay in) `FLUSH` with the counter reloaded to `FLUSH_CYCLES`;
  - `redirect_cnt` increments, saturating at 16'hFFFF;
  - `flush_id`=1 combinationally in the same cycle.
- `FLUSH`: the counter decrements every cycle, independent of stall. Go to `RUN` when it reaches 0. A new redirect during `FLUSH` reloads the counter.
- `stop` = `stall_req` in `RUN` or `FLUSH`. A redirect overrides the hold: `load_next_pc`=1 with `stop`=1 is legal, and the fetch stage loads the target.
- `inst_valid` = 1 only in `RUN` with no redirect in the current cycle. Stall does not clear it; decode qualifies it with `stall_req`.

## Timing
- Redirect at cycle N: `inst_valid`=0 in N, N+1 and N+2 (state `FLUSH`); the counter reaches 0 at the end of N+2.
- `inst_valid`=1 from N+3 with the target instruction, given `FLUSH_CYCLES`=2.
- Boot: `rst_n` rises before edge E0; `fetch_rst` falls after E1. With `BOOT_CYCLES`=3, `inst_valid` first rises 3 cycles later, aligned with the fetch stage's first instruction at PC 0.
- `rst_n` low mid-operation: all registers return to reset values immediately. The combinational outputs (`load_next_pc`, `next_pc`) stay masked until `BOOT` completes.
- `misalign_exc` is a single cycle even if the same misaligned request is held for several cycles. Each cycle of a held request counts as a new redirect.

## Structure
- `fetch_ctrl_pkg` contains:
  - the state enum (`BOOT`, `RUN`, `FLUSH`);
  - the redirect source enum (`SRC_NONE`, `SRC_TRAP`, `SRC_BRANCH`, `SRC_JUMP`);
  - default constants for the three parameters.
- Sub-module `rst_sync`: a 2-flop async-assert / sync-deassert synchronizer producing `fetch_rst`.

## Test plan
- Reset release: `rst_n` 0→1 → `fetch_rst` falls after 2 edges; `inst_valid` first 1 three cycles later; `stop`=0 and `load_next_pc`=0 throughout `BOOT`.
- Priority: `trap_req`, `branch_taken` and `jump_req` asserted together with targets 0x100, 0x200, 0x300 → `next_pc`=0x100; `redirect_cnt` +1; `inst_valid` 0 for 3 cycles.
- Stall plus redirect: `stall_req`=1 held while `branch_taken`=1 with target 0x40 → `stop`=1, `load_next_pc`=1, `next_pc`=0x40; FLUSH still ends after 2 cycles.
- Back-to-back: branch in cycle N, jump in cycle N+1 → counter reloaded; `inst_valid` 0 through N+3, 1 at N+4.
- Misaligned: `jump_target`=0x102 → `next_pc`=0x10; next cycle `misalign_exc`=1 and `misalign_addr`=0x102.
- Saturation and mid-op reset: force 65 540 redirects → `redirect_cnt` stays 0xFFFF; drop `rst_n` during FLUSH → all outputs return to reset values asynchronously.
